// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit with a single-beat bus, lane steering and bus timeout
module rv32i_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_VALID,
    output logic        O_READY,
    input  logic [31:0] I_ADDR,
    input  logic [31:0] I_WDATA,
    input  logic [2:0]  I_FUNCT3,
    input  logic        I_IS_STORE,
    output logic        O_DONE,
    output logic [31:0] O_RDATA,
    output logic        O_MISALIGN,
    output logic        O_FAULT,
    output logic        O_BUS_REQ,
    output logic        O_BUS_WE,
    output logic [31:0] O_BUS_ADDR,
    output logic [3:0]  O_BUS_BE,
    output logic [31:0] O_BUS_WDATA,
    input  logic        I_BUS_ACK,
    input  logic [31:0] I_BUS_RDATA
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic        store_q, misalign_q, fault_q;
    logic [CW-1:0] cnt_q;
    logic        illegal, misalign, in_bus;
    logic [31:0] lane, rdata_d;

    // Classify the incoming request; loads allow 000/001/010/100/101, stores only 000..010
    always_comb begin
        illegal  = I_IS_STORE ? (I_FUNCT3 > 3'd2) : (I_FUNCT3[1:0] == 2'b11 || I_FUNCT3 == 3'b110);
        misalign = (I_FUNCT3[1:0] == 2'b01 && I_ADDR[0]) || (I_FUNCT3[1:0] == 2'b10 && I_ADDR[1:0] != 2'b00);
    end

    // Select the addressed lane of the bus word and extend it to 32 bits
    always_comb begin
        lane    = I_BUS_RDATA >> {addr_q[1:0], 3'b000};
        rdata_d = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
    end

    assign in_bus      = state_q == BUS;
    assign O_READY     = state_q == IDLE;
    assign O_DONE      = state_q == DONE;
    assign O_RDATA     = rdata_q;
    assign O_MISALIGN  = misalign_q;
    assign O_FAULT     = fault_q;
    assign O_BUS_REQ   = in_bus;
    assign O_BUS_WE    = in_bus & store_q;
    assign O_BUS_ADDR  = in_bus ? {addr_q[31:2], 2'b00} : '0;
    assign O_BUS_BE    = !in_bus ? 4'b0000 :
                         f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                         f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    assign O_BUS_WDATA = !(in_bus && store_q) ? '0 :
                         f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                         f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;

    // Request FSM: accept in IDLE, hold the bus until ack or timeout, pulse DONE for one cycle
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            store_q    <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (I_VALID) begin
                    addr_q  <= I_ADDR;
                    wdata_q <= I_WDATA;
                    f3_q    <= I_FUNCT3;
                    store_q <= I_IS_STORE;
                    cnt_q   <= '0;
                    if (illegal || misalign) begin
                        state_q    <= DONE;
                        fault_q    <= illegal;
                        misalign_q <= ~illegal;
                    end else begin
                        state_q <= BUS;
                    end
                end
                BUS: if (I_BUS_ACK) begin
                    state_q <= DONE;
                    rdata_q <= store_q ? '0 : rdata_d;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == LAST) begin
                    state_q <= DONE;
                    fault_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                DONE: begin
                    state_q    <= IDLE;
                    rdata_q    <= '0;
                    misalign_q <= 1'b0;
                    fault_q    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: RV32I_LSU

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 16, bus-wait cycles before fault (0 = no timeout).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- I_CLK  in  1  clock, rising edge
- I_RST  in  1  async active-high reset
- I_VALID  in  1  request from execute stage
- O_READY  out  1  LSU can accept a request
- I_ADDR  in  32  effective address (ALU sum)
- I_WDATA  in  32  store source (rs2)
- I_FUNCT3  in  3  RV32I load/store funct3
- I_IS_STORE  in  1  1 = store, 0 = load
- O_DONE  out  1  one-cycle completion pulse
- O_RDATA  out  32  formatted load data
- O_MISALIGN  out  1  misaligned-address exception, valid with O_DONE
- O_FAULT  out  1  illegal funct3 or bus timeout, valid with O_DONE
- O_BUS_REQ  out  1  bus request
- O_BUS_WE  out  1  bus write enable
- O_BUS_ADDR  out  32  word-aligned address, {I_ADDR[31:2],2'b00}
- O_BUS_BE  out  4  byte enables
- O_BUS_WDATA  out  32  lane-replicated store data
- I_BUS_ACK  in  1  bus completion, one cycle
- I_BUS_RDATA  in  32  read data, valid with I_BUS_ACK

Function
REQ-004 The FSM SHALL have states IDLE, BUS, DONE; O_READY SHALL be 1 only in IDLE.
REQ-005 Accept SHALL occur at a rising edge with I_VALID=1 in IDLE; address, data, funct3 and store flag SHALL be latched at that edge.
REQ-006 Legal funct3 SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other SHALL be illegal.
REQ-007 Misalignment SHALL be: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-008 An illegal or misaligned request SHALL go IDLE->DONE directly with no bus cycle; O_FAULT=1 for illegal funct3, else O_MISALIGN=1 (illegal takes precedence).
REQ-009 A legal request SHALL go IDLE->BUS; in BUS, O_BUS_REQ=1 and all O_BUS_* SHALL stay stable until the ack edge.
REQ-010 O_BUS_BE SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-011 O_BUS_WDATA SHALL be: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; 0 for loads. O_BUS_WE = store flag.
REQ-012 On I_BUS_ACK in BUS, the FSM SHALL go to DONE; for loads it SHALL capture the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU), into O_RDATA.
REQ-013 DONE SHALL last exactly one cycle with O_DONE=1, then return to IDLE; O_RDATA SHALL be 0 for stores and for faulted or misaligned requests.
REQ-014 The zero-wait latency SHALL be: accept at edge k, O_BUS_REQ high during cycle k+1, ack sampled at edge k+1, O_DONE high during cycle k+2, O_READY high again from edge k+2.
REQ-015 With TIMEOUT_CYCLES>0, the FSM SHALL count BUS cycles; if no ack has been seen after TIMEOUT_CYCLES cycles, it SHALL drop O_BUS_REQ and go to DONE with O_FAULT=1.
REQ-016 An ack on the timeout edge SHALL win: normal completion, no fault.
REQ-017 I_BUS_ACK outside BUS SHALL be ignored; I_VALID outside IDLE SHALL be ignored (not queued).
REQ-018 O_MISALIGN, O_FAULT and O_RDATA SHALL be 0 whenever O_DONE=0.

Reset
REQ-019 I_RST=1 SHALL immediately force IDLE, O_READY=1, and all other outputs 0, including O_BUS_REQ; the timeout counter SHALL clear.
REQ-020 Reset during BUS SHALL abort the transaction with no O_DONE; a later ack SHALL be ignored.
REQ-021 After release, the first accept SHALL occur no earlier than the first rising edge with I_RST=0.

Verification
REQ-022 LB, addr 0x1003, bus rdata 0x80FF_0000, zero-wait ack -> BE=1000, O_RDATA=0xFFFF_FF80, O_DONE at cycle k+2.
REQ-023 SH, addr 0x2002, wdata 0x1234_ABCD -> BE=1100, WDATA=0xABCD_ABCD, WE=1, O_RDATA=0.
REQ-024 LW, addr 0x0006 -> no O_BUS_REQ, O_DONE+O_MISALIGN at cycle k+1; funct3=011 -> O_FAULT instead.
REQ-025 LHU, ack withheld, TIMEOUT_CYCLES=16 -> O_BUS_REQ for 16 cycles, then O_DONE+O_FAULT; repeat with ack on cycle 16 -> no fault.
REQ-026 Assert I_RST in BUS, then ack after release -> O_BUS_REQ low asynchronously, no O_DONE, O_READY=1.
REQ-027 Back-to-back I_VALID held high with zero-wait acks -> one accept every 3 cycles, and ignored requests never reach the bus.
